// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// datapath select encodings and the ALU-operation class handed to alu_decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_JAL, S_JALR, S_JALRWB, S_LUI, S_BRANCH
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU-operation class plus funct fields to the ALU control code.
import mc_ctrl_pkg::*;

module alu_decoder (
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    input  aluop_t     aluop,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type from I-type; addi never subtracts
                    3'b000:  aluControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  aluControl = ALU_AND;
                    3'b110:  aluControl = ALU_OR;
                    3'b100:  aluControl = ALU_XOR;
                    3'b010:  aluControl = ALU_SLT;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default:     aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM; outputs decode from state plus op/funct.
// Define MC_BRANCH_EXT_EN to enable bne/blt/bge in addition to beq.
import mc_ctrl_pkg::*;

module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic       regWrite,
    output logic [2:0] immSrc
);

    state_t state, state_nx;
    aluop_t aluop;
    logic   taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_RTYPE:          state_nx = S_EXECR;
                    OP_ITYPE:          state_nx = S_EXECI;
                    OP_BRANCH:         state_nx = S_BRANCH;
                    OP_JAL:            state_nx = S_JAL;
                    OP_JALR:           state_nx = S_JALR;
                    OP_LUI:            state_nx = S_LUI;
                    default:           state_nx = S_FETCH;
                endcase
            end
            S_MEMADR:  state_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_nx = S_MEMWB;
            S_EXECR:   state_nx = S_ALUWB;
            S_EXECI:   state_nx = S_ALUWB;
            S_JAL:     state_nx = S_ALUWB;
            S_JALR:    state_nx = S_JALRWB;
            default:   state_nx = S_FETCH;
        endcase
    end

`ifdef MC_BRANCH_EXT_EN
    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_lt;
    assign unused_lt = lt;
    assign taken     = (funct3 == 3'b000) && zero;
`endif

    always_comb begin
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        resultSrc = RES_ALUOUT;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        regWrite  = 1'b0;
        immSrc    = IMM_I;
        // IR is still loading during FETCH, so immSrc stays at its default there
        if (state != S_FETCH) begin
            case (op)
                OP_STORE:  immSrc = IMM_S;
                OP_BRANCH: immSrc = IMM_B;
                OP_LUI:    immSrc = IMM_U;
                OP_JAL:    immSrc = IMM_J;
                default:   immSrc = IMM_I;
            endcase
        end
        case (state)
            S_FETCH: begin
                irWrite = 1'b1; pcWrite = 1'b1; resultSrc = RES_ALURES;
                aluSrcA = SRCA_PC; aluSrcB = SRCB_FOUR;
            end
            S_DECODE:   begin aluSrcA = SRCA_OLDPC; aluSrcB = SRCB_IMM; end
            S_MEMADR:   begin aluSrcA = SRCA_RS1; aluSrcB = SRCB_IMM; end
            S_MEMREAD:  adrSrc = 1'b1;
            S_MEMWB:    begin resultSrc = RES_MEM; regWrite = 1'b1; end
            S_MEMWRITE: begin adrSrc = 1'b1; memWrite = 1'b1; end
            S_EXECR:    begin aluSrcA = SRCA_RS1; aluSrcB = SRCB_RS2; aluop = ALUOP_FUNCT; end
            S_EXECI:    begin aluSrcA = SRCA_RS1; aluSrcB = SRCB_IMM; aluop = ALUOP_FUNCT; end
            S_ALUWB:    begin resultSrc = RES_ALUOUT; regWrite = 1'b1; end
            S_JAL: begin
                aluSrcA = SRCA_OLDPC; aluSrcB = SRCB_FOUR; resultSrc = RES_ALUOUT; pcWrite = 1'b1;
            end
            S_JALR: begin
                aluSrcA = SRCA_RS1; aluSrcB = SRCB_IMM; resultSrc = RES_ALURES; pcWrite = 1'b1;
            end
            S_JALRWB: begin
                aluSrcA = SRCA_OLDPC; aluSrcB = SRCB_FOUR; resultSrc = RES_ALURES; regWrite = 1'b1;
            end
            S_LUI:      begin resultSrc = RES_IMM; regWrite = 1'b1; end
            S_BRANCH: begin
                aluSrcA = SRCA_RS1; aluSrcB = SRCB_RS2; aluop = ALUOP_SUB;
                resultSrc = RES_ALUOUT; pcWrite = taken;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opb5       (op[5]),
        .aluop      (aluop),
        .aluControl (aluControl)
    );

endmodule
